// File: rtl/ixc_uclk_pkg.sv
// Shared types for the emulated user-clock run-control block.
package ixc_uclk_pkg;

   // Host command opcodes as carried on cmd_op.
   typedef enum logic [1:0] {
      OP_NOP  = 2'b00,
      OP_RUN  = 2'b01,
      OP_STOP = 2'b10,
      OP_STEP = 2'b11
   } op_e;

   // Reason the last run or step ended, as reported on stop_cause.
   typedef enum logic [1:0] {
      CAUSE_NONE     = 2'd0,
      CAUSE_HOST     = 2'd1,
      CAUSE_STEPDONE = 2'd2,
      CAUSE_BRK      = 2'd3
   } cause_e;

   // Sequencer states.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STEP  = 2'd2,
      ST_DRAIN = 2'd3
   } state_e;

endpackage : ixc_uclk_pkg

// File: rtl/ixc_uclk_cyc_counter.sv
// Free-running count of enabled user-clock cycles with a priority clear.
module ixc_uclk_cyc_counter #(
   parameter int CYC_W = 48
) (
   input  logic             uclk,
   input  logic             rst_n,
   input  logic             en_i,
   input  logic             clr_i,
   output logic [CYC_W-1:0] cnt_o
);

   localparam logic [CYC_W-1:0] CYC_ONE = CYC_W'(1);

   logic [CYC_W-1:0] cnt_q;
   logic [CYC_W-1:0] cnt_d;

   // Next count: clear wins over a coincident increment; wrap is natural.
   always_comb begin
      // NOTE: assign a default first so no path leaves cnt_d unassigned and infers a latch.
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + CYC_ONE;
      end
   end

   // Count register.
   always_ff @(posedge uclk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule : ixc_uclk_cyc_counter

// File: rtl/ixc_uclk_step_ctrl.sv
// Run-control sequencer for the emulated user clock: turns host RUN/STOP/STEP
// commands and breakpoints into a registered gate enable, and reports why
// each run or step ended.
module ixc_uclk_step_ctrl
   import ixc_uclk_pkg::*;
#(
   parameter int CNT_W    = 32,
   parameter int CYC_W    = 48,
   parameter int STOP_LAT = 2
) (
   input  logic             uclk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [1:0]       cmd_op,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             brk,
   input  logic             cyc_clr,
   output logic             gate_en,
   output logic             running,
   output logic             done,
   output logic [1:0]       stop_cause,
   output logic             cmd_err,
   output logic [CYC_W-1:0] cyc_cnt
);

   // DRAIN holds gate_en low for STOP_LAT cycles; the counter loads STOP_LAT-1
   // on entry and the cycle it reaches zero is the last DRAIN cycle.
   localparam int                  DRAIN_W    = (STOP_LAT > 1) ? $clog2(STOP_LAT) : 1;
   localparam logic [DRAIN_W-1:0]  DRAIN_LOAD = DRAIN_W'(STOP_LAT - 1);
   localparam logic [DRAIN_W-1:0]  DRAIN_ONE  = DRAIN_W'(1);
   localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);

   state_e             state_q;
   cause_e             stop_cause_q;
   logic [CNT_W-1:0]   remaining_q;
   logic [DRAIN_W-1:0] drain_q;
   logic               gate_en_q;
   logic               running_q;
   logic               done_q;
   logic               cmd_err_q;

   op_e  op;
   logic cmd_acc;
   logic stop_acc;
   logic start_acc;
   logic step_last;

   assign op        = op_e'(cmd_op);
   assign cmd_ready = (state_q != ST_DRAIN);
   assign cmd_acc   = cmd_valid && cmd_ready;
   assign stop_acc  = cmd_acc && (op == OP_STOP);
   assign start_acc = cmd_acc && ((op == OP_RUN) || (op == OP_STEP));
   assign step_last = (state_q == ST_STEP) && (remaining_q == CNT_ONE);

   // Sequencer with all outputs registered alongside the state.
   always_ff @(posedge uclk or negedge rst_n) begin
      if (!rst_n) begin
         // The step count is ordinary control state, so it is reset with the
         // rest; a reset mid-run drops gate_en at once with no drain.
         state_q      <= ST_IDLE;
         stop_cause_q <= CAUSE_NONE;
         remaining_q  <= '0;
         drain_q      <= '0;
         gate_en_q    <= 1'b0;
         running_q    <= 1'b0;
         done_q       <= 1'b0;
         cmd_err_q    <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         done_q    <= 1'b0;
         cmd_err_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (cmd_acc) begin
                  case (op)
                     OP_RUN: begin
                        state_q      <= ST_RUN;
                        gate_en_q    <= 1'b1;
                        running_q    <= 1'b1;
                        stop_cause_q <= CAUSE_NONE;
                     end
                     OP_STEP: begin
                        if (cmd_count != '0) begin
                           state_q      <= ST_STEP;
                           remaining_q  <= cmd_count;
                           gate_en_q    <= 1'b1;
                           running_q    <= 1'b1;
                           stop_cause_q <= CAUSE_NONE;
                        end else begin
                           // A zero-length step completes without ever opening the gate.
                           state_q      <= ST_DRAIN;
                           drain_q      <= DRAIN_LOAD;
                           stop_cause_q <= CAUSE_STEPDONE;
                        end
                     end
                     default: ;
                  endcase
               end
            end

            ST_RUN, ST_STEP: begin
               if (start_acc) begin
                  cmd_err_q <= 1'b1;
               end
               if (state_q == ST_STEP) begin
                  remaining_q <= remaining_q - CNT_ONE;
               end
               // The cycle in which the stop event is sampled is still an
               // enabled cycle; the gate closes from the next one.
               if (brk || stop_acc || step_last) begin
                  state_q   <= ST_DRAIN;
                  drain_q   <= DRAIN_LOAD;
                  gate_en_q <= 1'b0;
                  running_q <= 1'b0;
                  stop_cause_q <= brk      ? CAUSE_BRK  :
                                  stop_acc ? CAUSE_HOST : CAUSE_STEPDONE;
               end
            end

            ST_DRAIN: begin
               if (drain_q == '0) begin
                  state_q <= ST_IDLE;
                  done_q  <= 1'b1;
               end else begin
                  drain_q <= drain_q - DRAIN_ONE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   ixc_uclk_cyc_counter #(
      .CYC_W (CYC_W)
   ) u_cyc_counter (
      .uclk  (uclk),
      .rst_n (rst_n),
      .en_i  (gate_en_q),
      .clr_i (cyc_clr),
      .cnt_o (cyc_cnt)
   );

   assign gate_en    = gate_en_q;
   assign running    = running_q;
   assign done       = done_q;
   assign cmd_err    = cmd_err_q;
   assign stop_cause = stop_cause_q;

endmodule : ixc_uclk_step_ctrl

// File: tb/tb_ixc_uclk_step_ctrl.sv
// Directed bench for the user-clock run-control sequencer (STOP_LAT = 2).
module tb_ixc_uclk_step_ctrl;
   import ixc_uclk_pkg::*;

   localparam int CNT_W    = 32;
   localparam int CYC_W    = 48;
   localparam int STOP_LAT = 2;

   logic             uclk;
   logic             rst_n;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_count;
   logic             brk;
   logic             cyc_clr;
   logic             gate_en;
   logic             running;
   logic             done;
   logic [1:0]       stop_cause;
   logic             cmd_err;
   logic [CYC_W-1:0] cyc_cnt;

   int n_vec = 0;
   int n_err = 0;

   ixc_uclk_step_ctrl #(
      .CNT_W    (CNT_W),
      .CYC_W    (CYC_W),
      .STOP_LAT (STOP_LAT)
   ) dut (
      .uclk       (uclk),
      .rst_n      (rst_n),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_op     (cmd_op),
      .cmd_count  (cmd_count),
      .brk        (brk),
      .cyc_clr    (cyc_clr),
      .gate_en    (gate_en),
      .running    (running),
      .done       (done),
      .stop_cause (stop_cause),
      .cmd_err    (cmd_err),
      .cyc_cnt    (cyc_cnt)
   );

   initial uclk = 1'b0;
   always #5 uclk = ~uclk;

   // Compare one observed value against its hand-computed expectation.
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge uclk);
      #1;
   endtask

   // Present one command for exactly one cycle.
   task automatic send(input op_e op, input logic [CNT_W-1:0] n);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_count = n;
      tick();
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cmd_count = '0;
   endtask

   // Clear the cycle counter from IDLE.
   task automatic clear_cnt();
      cyc_clr = 1'b1;
      tick();
      cyc_clr = 1'b0;
   endtask

   initial begin
      rst_n     = 1'b0;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
      cmd_count = '0;
      brk       = 1'b0;
      cyc_clr   = 1'b0;

      // ---- reset state
      tick();
      tick();
      chk("rst_gate_en",    gate_en,    0);
      chk("rst_running",    running,    0);
      chk("rst_done",       done,       0);
      chk("rst_cmd_err",    cmd_err,    0);
      chk("rst_stop_cause", stop_cause, 0);
      chk("rst_cyc_cnt",    cyc_cnt,    0);
      chk("rst_cmd_ready",  cmd_ready,  1);
      rst_n = 1'b1;
      tick();

      // ---- STEP N=5
      send(OP_STEP, 5);
      for (int i = 0; i < 5; i++) begin
         chk("step5_gate_on", gate_en, 1);
         chk("step5_done_lo", done, 0);
         tick();
      end
      chk("step5_gate_off",  gate_en,    0);
      chk("step5_running",   running,    0);
      chk("step5_ready_lo",  cmd_ready,  0);
      chk("step5_cyc_cnt",   cyc_cnt,    5);
      chk("step5_cause",     stop_cause, 2);
      tick();
      chk("step5_done_early", done, 0);
      tick();
      chk("step5_done",      done,      1);
      chk("step5_ready_hi",  cmd_ready, 1);
      tick();
      chk("step5_done_pulse", done, 0);

      // ---- RUN, breakpoint on the 10th enabled cycle
      clear_cnt();
      chk("clr_idle", cyc_cnt, 0);
      send(OP_RUN, 0);
      chk("run_gate_on", gate_en,    1);
      chk("run_running", running,    1);
      chk("run_cause0",  stop_cause, 0);
      for (int i = 0; i < 9; i++) tick();
      chk("run_gate_c10", gate_en, 1);
      brk = 1'b1;
      tick();
      chk("brk_gate_off", gate_en,    0);
      chk("brk_cyc_cnt",  cyc_cnt,    10);
      chk("brk_cause",    stop_cause, 3);
      tick();
      brk = 1'b0;
      chk("brk_drain_gate", gate_en, 0);
      chk("brk_done_early", done,    0);
      tick();
      chk("brk_done",  done,       1);
      chk("brk_cause_held", stop_cause, 3);
      tick();
      chk("brk_idle_gate", gate_en, 0);

      // ---- RUN, RUN while running (error), then STOP
      clear_cnt();
      send(OP_RUN, 0);
      tick();
      send(OP_RUN, 0);
      chk("rerun_err",     cmd_err,    1);
      chk("rerun_gate",    gate_en,    1);
      chk("rerun_running", running,    1);
      chk("rerun_cause",   stop_cause, 0);
      tick();
      chk("rerun_err_pulse", cmd_err, 0);
      send(OP_STOP, 0);
      chk("stop_gate_off", gate_en,    0);
      chk("stop_cause",    stop_cause, 1);
      chk("stop_cyc_cnt",  cyc_cnt,    4);
      tick();
      chk("stop_done_early", done, 0);
      tick();
      chk("stop_done", done, 1);

      // ---- STEP N=3, breakpoint on the final step cycle
      clear_cnt();
      send(OP_STEP, 3);
      tick();
      tick();
      chk("s3_gate_last", gate_en, 1);
      brk = 1'b1;
      tick();
      brk = 1'b0;
      chk("s3_gate_off", gate_en,    0);
      chk("s3_cyc_cnt",  cyc_cnt,    3);
      chk("s3_cause",    stop_cause, 3);
      tick();
      chk("s3_done_early", done, 0);
      tick();
      chk("s3_done", done, 1);
      tick();
      chk("s3_single_done", done, 0);

      // ---- STEP N=0
      send(OP_STEP, 0);
      chk("s0_gate",    gate_en,    0);
      chk("s0_running", running,    0);
      chk("s0_ready",   cmd_ready,  0);
      chk("s0_cause",   stop_cause, 2);
      tick();
      chk("s0_gate2",      gate_en, 0);
      chk("s0_done_early", done,    0);
      tick();
      chk("s0_done",    done,    1);
      chk("s0_cyc_cnt", cyc_cnt, 3);

      // ---- cyc_clr during RUN coinciding with an increment
      send(OP_RUN, 0);
      chk("clr_run_start", cyc_cnt, 3);
      tick();
      tick();
      chk("clr_run_pre", cyc_cnt, 5);
      cyc_clr = 1'b1;
      tick();
      cyc_clr = 1'b0;
      chk("clr_run_zero", cyc_cnt, 0);
      tick();
      chk("clr_run_resume", cyc_cnt, 1);
      send(OP_STOP, 0);
      chk("clr_run_stop", stop_cause, 1);
      tick();
      tick();
      chk("clr_run_done", done, 1);

      // ---- reset mid-STEP
      send(OP_STEP, 100);
      tick();
      tick();
      chk("mid_gate_pre", gate_en, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_gate",    gate_en,    0);
      chk("mid_rst_running", running,    0);
      chk("mid_rst_cyc_cnt", cyc_cnt,    0);
      chk("mid_rst_cause",   stop_cause, 0);
      chk("mid_rst_ready",   cmd_ready,  1);
      tick();
      chk("mid_rst_no_done", done, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_ready",   cmd_ready, 1);
      chk("post_rst_no_done", done,      0);
      send(OP_STEP, 2);
      chk("s2_gate1", gate_en, 1);
      tick();
      chk("s2_gate2", gate_en, 1);
      tick();
      chk("s2_gate_off", gate_en,    0);
      chk("s2_cyc_cnt",  cyc_cnt,    2);
      chk("s2_cause",    stop_cause, 2);
      tick();
      chk("s2_done_early", done, 0);
      tick();
      chk("s2_done", done, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Hard stop in case the directed sequence ever stalls.
   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected sequence end");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_ixc_uclk_step_ctrl
